// File: rtl/frame_capture_writer.sv
// frame_capture_writer: averages 8x8 green blocks of a 224x224 crop into a 28x28 BRAM image.
// Define BINARIZE_EN to store 16'hFFFF for dark blocks (avg < THRESHOLD), else 16'h0000.
module frame_capture_writer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int X0 = 48,
  parameter int Y0 = 8,
  parameter int THRESHOLD = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        vsync,
  input  logic        pixel_valid,
  input  logic [15:0] pixel_data,
  output logic [9:0]  bram_addr,
  output logic [15:0] bram_din,
  output logic        bram_we,
  output logic        bram_en,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_VSYNC = 2'd1, CAPTURE = 2'd2;
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE) + 1;
  logic [1:0] state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [11:0] acc [28];
  logic [31:0] xe, ye;
  logic [4:0] col, row;
  logic [5:0] green, avg;
  logic [11:0] sum;
  logic in_win, blk_done, last_x;
  logic [15:0] dout;
  assign xe = 32'(x);
  assign ye = 32'(y);
  assign in_win = xe >= X0 && xe < X0 + 224 && ye >= Y0 && ye < Y0 + 224;
  assign col = 5'((xe - X0) >> 3);
  assign row = 5'((ye - Y0) >> 3);
  assign blk_done = 3'(xe - X0) == 3'd7 && 3'(ye - Y0) == 3'd7;
  assign last_x = xe == H_ACTIVE - 1;
  assign green = 6'(pixel_data >> 5);
  assign sum = acc[col] + 12'(green);
  assign avg = 6'(sum >> 6);
  assign busy = state != IDLE;
`ifdef BINARIZE_EN
  assign dout = (avg < 6'(THRESHOLD)) ? 16'hFFFF : 16'h0000;
`else
  logic unused_thr;
  assign unused_thr = avg < 6'(THRESHOLD);
  assign dout = {10'b0, avg};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      for (int i = 0; i < 28; i++) acc[i] <= '0;
      bram_addr <= '0;
      bram_din <= '0;
      bram_we <= 1'b0;
      bram_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      bram_en <= 1'b0;
      frame_done <= 1'b0;
      if (state == IDLE && arm) state <= WAIT_VSYNC;
      if (state == WAIT_VSYNC && vsync) state <= CAPTURE;
      // counters stay cleared outside CAPTURE, so entering or restarting on vsync starts fresh
      if (state != CAPTURE || vsync) begin
        x <= '0;
        y <= '0;
        for (int i = 0; i < 28; i++) acc[i] <= '0;
      end else if (pixel_valid) begin
        x <= last_x ? '0 : x + 1'b1;
        if (last_x) y <= y + 1'b1;
        if (in_win) begin
          acc[col] <= blk_done ? '0 : sum;
          if (blk_done) begin
            bram_we <= 1'b1;
            bram_en <= 1'b1;
            bram_addr <= 10'(row) * 10'd28 + 10'(col);
            bram_din <= dout;
            if (row == 5'd27 && col == 5'd27) begin
              frame_done <= 1'b1;
              state <= IDLE;
            end
          end
        end
      end
    end
endmodule
